// File: rtl/adc128s022_channel_averager.sv
// ============================================================================
// Module  : adc128s022_channel_averager
// Purpose : 8-channel boxcar averager with sticky window alarms, fed from the
//           ADC128S022 controller through a round-robin shared accumulator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module adc128s022_channel_averager #(
    parameter int Avg_Log2 = 3
) (
    input  logic              clk,
    input  logic              clk_en,
    input  logic              sync_rst,
    input  logic [7:0][11:0]  sample_data,
    input  logic [7:0]        sample_valid,
    input  logic [11:0]       threshold_low,
    input  logic [11:0]       threshold_high,
    input  logic [7:0]        alarm_clear,
    output logic [7:0][11:0]  average_out,
    output logic [7:0]        average_valid,
    output logic [7:0]        alarm_low,
    output logic [7:0]        alarm_high,
    output logic [7:0]        overrun
);

    localparam int SW = 12 + Avg_Log2;
    localparam int CW = (Avg_Log2 > 0) ? Avg_Log2 : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((1 << Avg_Log2) - 1);

    logic [7:0]           r_pend;
    logic [7:0][11:0]     r_pend_data;
    logic [2:0]           r_last;
    logic [7:0][SW-1:0]   r_acc;
    logic [7:0][CW-1:0]   r_cnt;

    logic                 w_grant_any;
    logic [2:0]           w_grant_idx;
    logic [7:0]           w_grant_vec;
    logic [SW-1:0]        w_sum;
    logic [11:0]          w_avg;
    logic                 w_done;

    // Round-robin search starting one past the last serviced channel.
    always_comb begin
        logic [2:0] cand;
        w_grant_any = 1'b0;
        w_grant_idx = r_last;
        cand        = r_last;
        for (int k = 1; k <= 8; k++) begin
            cand = r_last + 3'(k);
            if (!w_grant_any && r_pend[cand]) begin
                w_grant_any = 1'b1;
                w_grant_idx = cand;
            end
        end
    end

    assign w_grant_vec = w_grant_any ? (8'b1 << w_grant_idx) : 8'b0;
    assign w_sum       = r_acc[w_grant_idx] + SW'(r_pend_data[w_grant_idx]);
    assign w_avg       = 12'(w_sum >> Avg_Log2);
    assign w_done      = (r_cnt[w_grant_idx] == CNT_MAX);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_pend        <= '0;
            r_pend_data   <= '0;
            r_last        <= 3'd7;
            r_acc         <= '0;
            r_cnt         <= '0;
            average_out   <= '0;
            average_valid <= '0;
            alarm_low     <= '0;
            alarm_high    <= '0;
            overrun       <= '0;
        end else if (clk_en) begin
            average_valid <= '0;
            // Clears are issued first so that any set later in this block wins.
            alarm_low  <= alarm_low  & ~alarm_clear;
            alarm_high <= alarm_high & ~alarm_clear;
            overrun    <= overrun    & ~alarm_clear;

            for (int i = 0; i < 8; i++) begin
                if (sample_valid[i]) begin
                    r_pend_data[i] <= sample_data[i];
                    if (r_pend[i] && !w_grant_vec[i])
                        overrun[i] <= 1'b1;
                end
            end
            r_pend <= (r_pend & ~w_grant_vec) | sample_valid;

            if (w_grant_any) begin
                r_last <= w_grant_idx;
                if (!w_done) begin
                    r_acc[w_grant_idx] <= w_sum;
                    r_cnt[w_grant_idx] <= r_cnt[w_grant_idx] + CW'(1);
                end else begin
                    average_out[w_grant_idx]   <= w_avg;
                    average_valid[w_grant_idx] <= 1'b1;
                    r_acc[w_grant_idx]         <= '0;
                    r_cnt[w_grant_idx]         <= '0;
                    if (w_avg < threshold_low)
                        alarm_low[w_grant_idx] <= 1'b1;
                    if (w_avg > threshold_high)
                        alarm_high[w_grant_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adc128s022_channel_averager.sv
// ============================================================================
// Module  : tb_adc128s022_channel_averager
// Purpose : Checks two averager instances (8-sample and pass-through) against
//           a per-cycle reference model built on sample lists.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adc128s022_channel_averager;

    logic             clk;
    logic             en;
    logic             rst;
    logic [7:0][11:0] sd;
    logic [7:0]       sv;
    logic [11:0]      thl;
    logic [11:0]      thh;
    logic [7:0]       clr;

    logic [7:0][11:0] a3_out, a0_out;
    logic [7:0]       a3_vld, a3_alo, a3_ahi, a3_ovr;
    logic [7:0]       a0_vld, a0_alo, a0_ahi, a0_ovr;

    int n_total = 0;
    int n_bad   = 0;
    int pulse3[8];

    adc128s022_channel_averager #(.Avg_Log2(3)) dut_a3 (
        .clk(clk), .clk_en(en), .sync_rst(rst),
        .sample_data(sd), .sample_valid(sv),
        .threshold_low(thl), .threshold_high(thh), .alarm_clear(clr),
        .average_out(a3_out), .average_valid(a3_vld),
        .alarm_low(a3_alo), .alarm_high(a3_ahi), .overrun(a3_ovr));

    adc128s022_channel_averager #(.Avg_Log2(0)) dut_a0 (
        .clk(clk), .clk_en(en), .sync_rst(rst),
        .sample_data(sd), .sample_valid(sv),
        .threshold_low(thl), .threshold_high(thh), .alarm_clear(clr),
        .average_out(a0_out), .average_valid(a0_vld),
        .alarm_low(a0_alo), .alarm_high(a0_ahi), .overrun(a0_ovr));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model state: index 0 = 8-sample instance, 1 = pass-through.
    bit m_pend[2][8];
    int m_pdata[2][8];
    int m_last[2];
    int m_q[2][8][$];
    int m_avg[2][8];
    bit m_avv[2][8];
    bit m_alo[2][8];
    bit m_ahi[2][8];
    bit m_ovr[2][8];

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_update(input int u);
        int n, g, c, s, a;
        bit op[8];
        n = (u == 0) ? 8 : 1;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[u][i] = 0; m_pdata[u][i] = 0; m_q[u][i].delete();
                m_avg[u][i] = 0; m_avv[u][i] = 0;
                m_alo[u][i] = 0; m_ahi[u][i] = 0; m_ovr[u][i] = 0;
            end
            m_last[u] = 7;
            return;
        end
        if (!en) return;
        g = -1;
        for (int k = 1; k <= 8; k++) begin
            c = (m_last[u] + k) % 8;
            if (g < 0 && m_pend[u][c]) g = c;
        end
        for (int i = 0; i < 8; i++) begin
            op[i] = m_pend[u][i];
            m_avv[u][i] = 0;
            if (clr[i]) begin
                m_alo[u][i] = 0; m_ahi[u][i] = 0; m_ovr[u][i] = 0;
            end
        end
        if (g >= 0) begin
            m_q[u][g].push_back(m_pdata[u][g]);
            m_pend[u][g] = 0;
            m_last[u] = g;
            if (m_q[u][g].size() == n) begin
                s = 0;
                foreach (m_q[u][g][j]) s += m_q[u][g][j];
                a = s / n;
                m_avg[u][g] = a;
                m_avv[u][g] = 1;
                if (a < int'(thl)) m_alo[u][g] = 1;
                if (a > int'(thh)) m_ahi[u][g] = 1;
                m_q[u][g].delete();
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (sv[i]) begin
                if (op[i] && g != i) m_ovr[u][i] = 1;
                m_pdata[u][i] = int'(sd[i]);
                m_pend[u][i] = 1;
            end
        end
    endfunction

    task automatic compare_inst(input int u, input logic [95:0] out, input logic [7:0] vld,
                                input logic [7:0] alo, input logic [7:0] ahi, input logic [7:0] ovr);
        logic [95:0] e_out;
        logic [7:0]  e_vld, e_alo, e_ahi, e_ovr;
        string sfx;
        sfx = (u == 0) ? "_a3" : "_a0";
        for (int i = 0; i < 8; i++) begin
            e_out[i*12 +: 12] = 12'(m_avg[u][i]);
            e_vld[i] = m_avv[u][i];
            e_alo[i] = m_alo[u][i];
            e_ahi[i] = m_ahi[u][i];
            e_ovr[i] = m_ovr[u][i];
        end
        check_val({"average_out", sfx}, out, e_out);
        check_val({"average_valid", sfx}, {88'd0, vld}, {88'd0, e_vld});
        check_val({"alarm_low", sfx}, {88'd0, alo}, {88'd0, e_alo});
        check_val({"alarm_high", sfx}, {88'd0, ahi}, {88'd0, e_ahi});
        check_val({"overrun", sfx}, {88'd0, ovr}, {88'd0, e_ovr});
    endtask

    task automatic step();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        compare_inst(0, a3_out, a3_vld, a3_alo, a3_ahi, a3_ovr);
        compare_inst(1, a0_out, a0_vld, a0_alo, a0_ahi, a0_ovr);
        if (en && !rst)
            for (int i = 0; i < 8; i++) if (a3_vld[i]) pulse3[i]++;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic strobe(input int ch, input int val);
        sd[ch] = 12'(val); sv = 8'b1 << ch;
        step();
        sv = '0;
        step(); step();
    endtask

    initial begin
        int others;
        int samples;
        en = 1'b1; rst = 1'b0; sd = '0; sv = '0; clr = '0;
        thl = 12'd0; thh = 12'hFFF;
        foreach (pulse3[i]) pulse3[i] = 0;

        // Reset state
        do_reset();
        check_val("reset_out", a3_out, 96'd0);
        check_val("reset_flags", {64'd0, a3_vld, a3_alo, a3_ahi, a3_ovr}, 96'd0);

        // Eight ch2 samples -> single average
        foreach (pulse3[i]) pulse3[i] = 0;
        for (int k = 0; k < 8; k++) strobe(2, 100 + 2 * k);
        check_val("ch2_avg", {84'd0, a3_out[2]}, 96'd107);
        check_val("ch2_pulses", 96'(pulse3[2]), 96'd1);
        others = 0;
        for (int i = 0; i < 8; i++) if (i != 2) others += pulse3[i];
        check_val("ch2_only", 96'(others), 96'd0);

        // All eight channels at once; pass-through instance drains in order
        do_reset();
        for (int i = 0; i < 8; i++) sd[i] = 12'(16 * i);
        sv = 8'hFF; step(); sv = '0;
        for (int k = 0; k < 10; k++) step();
        check_val("all8_vals_a0", a0_out,
                  {12'd112, 12'd96, 12'd80, 12'd64, 12'd48, 12'd32, 12'd16, 12'd0});

        // Overrun on ch5 across a clk_en-low gap
        do_reset();
        sd[5] = 12'd111; sv = 8'h3F; step();
        sv = '0; en = 1'b0; step(); step(); step();
        en = 1'b1; sd[5] = 12'd777; sv = 8'h20; step();
        sv = '0;
        for (int k = 0; k < 10; k++) step();
        check_val("ovr5_set", {88'd0, a0_ovr}, {88'd0, 8'h20});
        check_val("ovr5_value", {84'd0, a0_out[5]}, 96'd777);
        clr = 8'h20; step(); clr = '0; step();
        check_val("ovr5_clear", {88'd0, a3_ovr}, 96'd0);

        // Threshold boundaries on ch1
        do_reset();
        thl = 12'd1000; thh = 12'd3000;
        for (int k = 0; k < 8; k++) strobe(1, 999);
        check_val("thr_999", {94'd0, a3_alo[1], a3_ahi[1]}, 96'b10);
        for (int k = 0; k < 8; k++) strobe(1, 1000);
        for (int k = 0; k < 8; k++) strobe(1, 3000);
        check_val("thr_3000", {94'd0, a3_alo[1], a3_ahi[1]}, 96'b10);
        for (int k = 0; k < 8; k++) strobe(1, 3001);
        check_val("thr_3001", {94'd0, a3_alo[1], a3_ahi[1]}, 96'b11);
        clr = 8'h02; step(); clr = '0; step();
        check_val("thr_clear", {94'd0, a3_alo[1], a3_ahi[1]}, 96'b00);

        // Reset mid-accumulation
        thl = 12'd0; thh = 12'hFFF;
        for (int k = 0; k < 5; k++) strobe(3, 50);
        do_reset();
        check_val("midrst_flags", {64'd0, a3_vld, a3_alo, a3_ahi, a3_ovr}, 96'd0);
        for (int k = 0; k < 8; k++) strobe(3, 4095);
        check_val("midrst_avg", {84'd0, a3_out[3]}, 96'd4095);

        // Randomized: clk_en one cycle in four, random strobe mix
        do_reset();
        thl = 12'd1700; thh = 12'd2400;
        samples = 0;
        for (int cyc = 0; cyc < 60000 && samples < 10000; cyc++) begin
            en  = ($urandom % 4) == 0;
            rst = ($urandom % 8000) == 0;
            for (int i = 0; i < 8; i++) sd[i] = 12'($urandom);
            sv  = 8'($urandom & $urandom & $urandom);
            clr = (($urandom % 32) == 0) ? 8'($urandom) : 8'd0;
            if (($urandom % 500) == 0) begin
                thl = 12'($urandom_range(1500, 2100));
                thh = 12'($urandom_range(1900, 2600));
            end
            if (en && !rst) samples += $countones(sv);
            step();
        end
        rst = 1'b0; en = 1'b1; sv = '0; clr = '0;
        for (int k = 0; k < 12; k++) step();
        check_val("random_sample_count", 96'(samples >= 10000), 96'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
